// File: rtl/stage_loader.sv
// stage_loader
//   Copies one stage layout out of the stage ROM into the live brick map at
//   level start. ROM rows 0..ROWS-1 are read in order. Each row is written to
//   the brick map one cycle later, and the breakable bricks are counted as the
//   rows go past.
//
// Ports
//   clock        system clock, all state on the rising edge
//   reset_n      synchronous reset, active-low
//   start        load request, only honoured while idle
//   stage_sel    stage to load, latched when start is accepted
//   busy         high while a load is running (fetch and drain)
//   done         one-cycle pulse once the map and brick_count are final
//   brick_count  number of breakable bricks in the loaded stage
//   rom_enable   stage ROM read enable
//   rom_addr     stage ROM row address
//   rom_stage    stage ROM stage select (latched stage_sel)
//   rom_data     stage ROM row, valid one cycle after the read
//   map_we       brick-map write enable
//   map_addr     brick-map row address
//   map_data     brick-map row data, code c at bits [ROW_W-1-CODE_W*c -: CODE_W]
module stage_loader #(
  parameter int ROWS = 30,
  parameter int COLS = 10,
  parameter int CODE_W = 3,
  parameter logic [CODE_W-1:0] UNBREAKABLE = 3'b111
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [1:0]               stage_sel,
  output logic                     busy,
  output logic                     done,
  output logic [8:0]               brick_count,
  output logic                     rom_enable,
  output logic [4:0]               rom_addr,
  output logic [1:0]               rom_stage,
  input  logic [COLS*CODE_W-1:0]   rom_data,
  output logic                     map_we,
  output logic [4:0]               map_addr,
  output logic [COLS*CODE_W-1:0]   map_data
);

  localparam int ROW_W = COLS * CODE_W;
  localparam int SUM_W = $clog2(COLS + 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [1:0]        stage_q;
  logic [4:0]        row_cnt;
  logic [SUM_W-1:0]  row_bricks;
  logic [CODE_W-1:0] code;

  // Next-state logic. Start is only looked at in IDLE, so requests made
  // while a load is running or during the done pulse are simply dropped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   if (row_cnt == LAST_ROW) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status and ROM-side outputs come straight from registered state so
  // nothing on the ROM or map interface depends combinationally on start.
  // rom_addr is parked at 0 outside FETCH so it never shows row ROWS.
  always_comb begin
    busy       = (state == FETCH) || (state == DRAIN);
    done       = (state == DONE);
    rom_enable = (state == FETCH);
    rom_addr   = (state == FETCH) ? row_cnt : 5'd0;
    rom_stage  = stage_q;
  end

  // The ROM answers one cycle after the read, so its data is passed straight
  // through to the map in the write cycle. Stage 0 means "no stage": the ROM
  // is still read but every row is written as empty, clearing the map.
  always_comb begin
    map_data = '0;
    if (map_we && (stage_q != 2'b00)) map_data = rom_data;
  end

  // Count the breakable codes in the row being written this cycle.
  always_comb begin
    row_bricks = '0;
    code       = '0;
    for (int c = 0; c < COLS; c++) begin
      code = map_data[ROW_W-1-CODE_W*c -: CODE_W];
      if ((code != '0) && (code != UNBREAKABLE)) row_bricks = row_bricks + 1'b1;
    end
  end

  // Sequential state: FSM register, row counter, the one-cycle write
  // pipeline and the running brick count. A reset mid-load drops straight
  // back to idle with no done pulse.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      stage_q     <= 2'b00;
      row_cnt     <= 5'd0;
      map_we      <= 1'b0;
      map_addr    <= 5'd0;
      brick_count <= 9'd0;
    end else begin
      state    <= state_next;
      map_we   <= (state == FETCH);
      map_addr <= (state == FETCH) ? row_cnt : 5'd0;
      if ((state == IDLE) && start) begin
        stage_q     <= stage_sel;
        row_cnt     <= 5'd0;
        brick_count <= 9'd0;
      end else begin
        if (state == FETCH) row_cnt <= row_cnt + 5'd1;
        if (map_we) brick_count <= brick_count + 9'(row_bricks);
      end
    end
  end

endmodule

// File: tb/tb_stage_loader.sv
// tb_stage_loader
//   Self-checking bench for stage_loader. A small ROM model answers reads one
//   cycle late. Each load pushes its expected map writes and final brick
//   count into queues; a monitor pops and compares on every write and every
//   done pulse, and also follows the ROM address sequence.
module tb_stage_loader;

  typedef struct packed {
    logic [4:0]  addr;
    logic [29:0] data;
  } wr_t;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [1:0]  stage_sel;
  logic        busy;
  logic        done;
  logic [8:0]  brick_count;
  logic        rom_enable;
  logic [4:0]  rom_addr;
  logic [1:0]  rom_stage;
  logic [29:0] rom_data;
  logic        map_we;
  logic [4:0]  map_addr;
  logic [29:0] map_data;

  logic [29:0] romMem [4][32];
  wr_t         expWrites[$];
  int          expCounts[$];
  int          compared;
  int          mismatched;

  stage_loader dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .stage_sel   (stage_sel),
    .busy        (busy),
    .done        (done),
    .brick_count (brick_count),
    .rom_enable  (rom_enable),
    .rom_addr    (rom_addr),
    .rom_stage   (rom_stage),
    .rom_data    (rom_data),
    .map_we      (map_we),
    .map_addr    (map_addr),
    .map_data    (map_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stage ROM model with one cycle of read latency.
  always @(posedge clock) begin
    if (rom_enable === 1'b1) rom_data <= romMem[rom_stage][rom_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every map write and every done pulse against the
  // scoreboard, and checks the ROM walks 0,1,2,... while enabled.
  initial begin : monitor
    int  expRomAddr;
    wr_t w;
    int  c;
    expRomAddr = 0;
    forever begin
      @(negedge clock);
      if (rom_enable === 1'b1) begin
        checkOutput("romAddr", 32'(rom_addr), 32'(expRomAddr));
        expRomAddr++;
      end else begin
        expRomAddr = 0;
      end
      if (map_we === 1'b1) begin
        if (expWrites.size() == 0) begin
          checkOutput("unexpectedWrite", 32'(map_addr), 32'hFFFF_FFFF);
        end else begin
          w = expWrites.pop_front();
          checkOutput("mapAddr", 32'(map_addr), 32'(w.addr));
          checkOutput("mapData", 32'(map_data), 32'(w.data));
        end
      end
      if (done === 1'b1) begin
        if (expCounts.size() == 0) begin
          checkOutput("unexpectedDone", 32'(done), 32'd0);
        end else begin
          c = expCounts.pop_front();
          checkOutput("brickCount", 32'(brick_count), 32'(c));
        end
      end
    end
  end

  // Pushes the expected writes of a load (all rows, or only those that
  // complete before an abort) and, for a full load, the final count.
  task automatic queueLoad(input logic [1:0] stage, input int nRows, input int expCount, input bit full);
    wr_t w;
    for (int r = 0; r < nRows; r++) begin
      w.addr = 5'(r);
      w.data = (stage == 2'b00) ? 30'd0 : romMem[stage][r];
      expWrites.push_back(w);
    end
    if (full) expCounts.push_back(expCount);
  endtask

  // Runs one load. pulseStart re-pulses start in cycles 5 and 31; a nonzero
  // abortCycle pulls reset_n low during that cycle instead of finishing.
  task automatic applyStimulus(input logic [1:0] stage, input int expCount,
                               input bit pulseStart, input int abortCycle);
    int cyc;
    int busyErr;
    int sawDone;
    if (abortCycle != 0) queueLoad(stage, abortCycle - 1, expCount, 1'b0);
    else queueLoad(stage, 30, expCount, 1'b1);
    @(negedge clock);
    stage_sel = stage;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    stage_sel = ~stage;
    cyc = 1;
    checkOutput("romStageLatched", 32'(rom_stage), 32'(stage));
    busyErr = 0;
    if (abortCycle != 0) begin
      while (cyc < abortCycle) begin
        if (busy !== 1'b1) busyErr++;
        @(posedge clock);
        #1;
        cyc++;
      end
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      checkOutput("abortBusyDuring", 32'(busyErr), 32'd0);
      checkOutput("abortBusy", 32'(busy), 32'd0);
      checkOutput("abortMapWe", 32'(map_we), 32'd0);
      checkOutput("abortRomEnable", 32'(rom_enable), 32'd0);
      checkOutput("abortCount", 32'(brick_count), 32'd0);
      sawDone = 0;
      for (int i = 0; i < 35; i++) begin
        if (done !== 1'b0) sawDone++;
        @(posedge clock);
        #1;
      end
      checkOutput("abortNoDone", 32'(sawDone), 32'd0);
      checkOutput("abortWritesLeft", 32'(expWrites.size()), 32'd0);
    end else begin
      while ((done !== 1'b1) && (cyc < 40)) begin
        start = (pulseStart && (cyc == 5 || cyc == 31)) ? 1'b1 : 1'b0;
        if (busy !== 1'b1) busyErr++;
        @(posedge clock);
        #1;
        cyc++;
      end
      start = 1'b0;
      checkOutput("doneCycle", 32'(cyc), 32'd32);
      checkOutput("busyCycles1to31", 32'(busyErr), 32'd0);
      checkOutput("busyInDone", 32'(busy), 32'd0);
      checkOutput("writesLeft", 32'(expWrites.size()), 32'd0);
      @(posedge clock);
      #1;
      checkOutput("donePulseLen", 32'(done), 32'd0);
      checkOutput("countsLeft", 32'(expCounts.size()), 32'd0);
      checkOutput("countHold", 32'(brick_count), 32'(expCount));
      checkOutput("idleAfterLoad", 32'(busy), 32'd0);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    start      = 1'b1;
    stage_sel  = 2'b11;
    for (int s = 0; s < 4; s++)
      for (int r = 0; r < 32; r++) romMem[s][r] = 30'o1111111111;
    for (int r = 0; r < 32; r++) romMem[0][r] = 30'o5555555555;
    for (int r = 0; r < 32; r++) romMem[2][r] = 30'o2222222222;
    romMem[2][0] = 30'o0000000000;
    for (int r = 0; r < 16; r++) romMem[3][r] = 30'o1234565432;
    romMem[3][16] = 30'o7000000001;
    for (int r = 17; r < 21; r++) romMem[3][r] = 30'o7777777777;
    for (int r = 21; r < 30; r++) romMem[3][r] = 30'o0000000000;

    // Reset held for three cycles with start high.
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstCount", 32'(brick_count), 32'd0);
    checkOutput("rstRomEnable", 32'(rom_enable), 32'd0);
    checkOutput("rstRomAddr", 32'(rom_addr), 32'd0);
    checkOutput("rstRomStage", 32'(rom_stage), 32'd0);
    checkOutput("rstMapWe", 32'(map_we), 32'd0);
    checkOutput("rstMapAddr", 32'(map_addr), 32'd0);
    checkOutput("rstMapData", 32'(map_data), 32'd0);
    start   = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // All rows 001: 30 rows x 10 bricks.
    applyStimulus(2'b01, 300, 1'b0, 0);
    // Row 5 unbreakable, the rest 001.
    romMem[1][5] = 30'o7777777777;
    applyStimulus(2'b01, 290, 1'b0, 0);
    // Mixed stage: 16 full rows, one row with a single breakable brick.
    applyStimulus(2'b11, 161, 1'b0, 0);
    // No stage: map cleared, stray starts ignored.
    applyStimulus(2'b00, 0, 1'b1, 0);
    // Abort in cycle 12, then a clean reload of the same stage.
    applyStimulus(2'b10, 290, 1'b0, 12);
    applyStimulus(2'b10, 290, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
